// File: rtl/fabric_credit_tx_if.sv
// rtl/fabric_credit_tx_if.sv - local stream, link, credit and drain signals of fabric_credit_tx
// Stats signals exist only when FABRIC_CREDIT_TX_STATS_EN is defined.
interface fabric_credit_tx_if #(
  parameter int CREDITS    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 0
);
  localparam int PAYLOAD_WIDTH = DATA_WIDTH + TAG_WIDTH;
  localparam int CNT_WIDTH     = $clog2(CREDITS + 1);

  logic                     in_valid;
  logic                     in_ready;
  logic [PAYLOAD_WIDTH-1:0] in_data;
  logic                     link_valid;
  logic [PAYLOAD_WIDTH-1:0] link_data;
  logic                     credit_ret;
  logic                     drain_req;
  logic                     drain_done;
  logic [CNT_WIDTH-1:0]     credit_cnt;
  logic                     credit_err;
`ifdef FABRIC_CREDIT_TX_STATS_EN
  logic [31:0]              stat_beats;
  logic [31:0]              stat_stalls;

  modport slave (
    input  in_valid, in_data, credit_ret, drain_req,
    output in_ready, link_valid, link_data, drain_done, credit_cnt, credit_err,
    output stat_beats, stat_stalls
  );

  modport master (
    output in_valid, in_data, credit_ret, drain_req,
    input  in_ready, link_valid, link_data, drain_done, credit_cnt, credit_err,
    input  stat_beats, stat_stalls
  );
`else
  modport slave (
    input  in_valid, in_data, credit_ret, drain_req,
    output in_ready, link_valid, link_data, drain_done, credit_cnt, credit_err
  );

  modport master (
    output in_valid, in_data, credit_ret, drain_req,
    input  in_ready, link_valid, link_data, drain_done, credit_cnt, credit_err
  );
`endif
endinterface

// File: rtl/fabric_credit_tx.sv
// rtl/fabric_credit_tx.sv - credit-based fabric link transmitter with drain state machine
// Optional beat/stall counters enabled by defining FABRIC_CREDIT_TX_STATS_EN.
module fabric_credit_tx #(
  parameter int CREDITS    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fabric_credit_tx_if.slave     bus
);
  localparam int PAYLOAD_WIDTH = DATA_WIDTH + TAG_WIDTH;
  localparam int CNT_WIDTH     = $clog2(CREDITS + 1);
  localparam logic [CNT_WIDTH-1:0] FULL = CNT_WIDTH'(CREDITS);
  localparam logic [CNT_WIDTH-1:0] ONE  = CNT_WIDTH'(1);

  if (CREDITS < 1) begin : g_bad_credits
    $fatal(1, "fabric_credit_tx: CREDITS must be >= 1");
  end
  if (DATA_WIDTH <= 0) begin : g_bad_width
    $fatal(1, "fabric_credit_tx: DATA_WIDTH must be > 0");
  end

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [CNT_WIDTH-1:0]     r_credit_cnt;
  logic [CNT_WIDTH-1:0]     w_cnt_nxt;
  logic                     r_credit_err;
  logic                     w_err_set;
  logic                     r_link_valid;
  logic [PAYLOAD_WIDTH-1:0] r_link_data;
  logic                     w_in_ready;
  logic                     w_drain_done;
  logic                     w_accept;
  logic                     w_full;

  assign w_full   = (r_credit_cnt == FULL);
  assign w_accept = bus.in_valid && w_in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // in_ready depends only on registered state, never on in_valid
  always_comb begin
    w_state_nxt  = r_state;
    w_in_ready   = 1'b0;
    w_drain_done = 1'b0;
    unique case (r_state)
      S_RUN: begin
        w_in_ready = (r_credit_cnt != '0);
        if (bus.drain_req) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!bus.drain_req) begin
          w_state_nxt = S_RUN;
        end else if (w_full) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_drain_done = 1'b1;
        if (!bus.drain_req) begin
          w_state_nxt = S_RUN;
        end
      end
      default: begin
        w_state_nxt = S_RUN;
      end
    endcase
  end

  // A return with no accept at a full count is a remote protocol error
  always_comb begin
    w_cnt_nxt = r_credit_cnt;
    w_err_set = 1'b0;
    unique case ({w_accept, bus.credit_ret})
      2'b10: w_cnt_nxt = r_credit_cnt - ONE;
      2'b01: begin
        if (w_full) begin
          w_err_set = 1'b1;
        end else begin
          w_cnt_nxt = r_credit_cnt + ONE;
        end
      end
      default: w_cnt_nxt = r_credit_cnt;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_credit_cnt <= FULL;
      r_credit_err <= 1'b0;
      r_link_valid <= 1'b0;
      r_link_data  <= '0;
    end else begin
      r_credit_cnt <= w_cnt_nxt;
      r_credit_err <= r_credit_err | w_err_set;
      r_link_valid <= w_accept;
      if (w_accept) begin
        r_link_data <= bus.in_data;
      end
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.drain_done = w_drain_done;
  assign bus.link_valid = r_link_valid;
  assign bus.link_data  = r_link_data;
  assign bus.credit_cnt = r_credit_cnt;
  assign bus.credit_err = r_credit_err;

`ifdef FABRIC_CREDIT_TX_STATS_EN
  logic [31:0] r_stat_beats;
  logic [31:0] r_stat_stalls;
  logic        w_stall;

  assign w_stall = bus.in_valid && (r_state == S_RUN) && (r_credit_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_beats  <= '0;
      r_stat_stalls <= '0;
    end else begin
      if (w_accept) begin
        r_stat_beats <= r_stat_beats + 32'd1;
      end
      if (w_stall) begin
        r_stat_stalls <= r_stat_stalls + 32'd1;
      end
    end
  end

  assign bus.stat_beats  = r_stat_beats;
  assign bus.stat_stalls = r_stat_stalls;
`endif
endmodule

// File: tb/tb_fabric_credit_tx.sv
// tb/tb_fabric_credit_tx.sv - vector table, corner sequences and random run against a credit model
// Stats checks are compiled in when FABRIC_CREDIT_TX_STATS_EN is defined.
module tb_fabric_credit_tx;
  localparam int CREDITS = 2;
  localparam int DW      = 32;
  localparam int TW      = 0;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fabric_credit_tx_if #(.CREDITS(CREDITS), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();

  fabric_credit_tx #(.CREDITS(CREDITS), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        ret;
    logic        drn;
    logic        rdy;
    logic        lv;
    logic [31:0] ld;
    logic [1:0]  cnt;
    logic        err;
    logic        dd;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic iv, logic [31:0] d, logic ret, logic drn, logic rdy,
                              logic lv, logic [31:0] ld, logic [1:0] cnt, logic err, logic dd);
    vec_t v;
    v.iv = iv; v.d = d; v.ret = ret; v.drn = drn; v.rdy = rdy;
    v.lv = lv; v.ld = ld; v.cnt = cnt; v.err = err; v.dd = dd;
    vecs.push_back(v);
  endfunction

  task automatic drive(input logic iv, input logic [31:0] d, input logic ret, input logic drn);
    bus.in_valid   = iv;
    bus.in_data    = d;
    bus.credit_ret = ret;
    bus.drain_req  = drn;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reference: credits as a plain integer, mode 0=run 1=drain 2=done
  int          m_cred;
  int          m_mode;
  logic        m_err;
  logic        m_lv;
  logic [31:0] m_ld;
  logic [31:0] m_beats;
  logic [31:0] m_stalls;

  task automatic model_reset();
    m_cred = CREDITS; m_mode = 0; m_err = 1'b0; m_lv = 1'b0; m_ld = '0;
    m_beats = '0; m_stalls = '0;
  endtask

  function automatic logic model_ready();
    return (m_mode == 0) && (m_cred > 0);
  endfunction

  task automatic model_step(input logic iv, input logic [31:0] d, input logic ret, input logic drn);
    logic acc;
    int   old;
    acc = iv && model_ready();
    old = m_cred;
    if (iv && m_mode == 0 && m_cred == 0) m_stalls = m_stalls + 32'd1;
    if (acc) m_beats = m_beats + 32'd1;
    m_cred = m_cred - int'(acc) + int'(ret);
    if (m_cred > CREDITS) begin
      m_cred = CREDITS;
      m_err  = 1'b1;
    end
    case (m_mode)
      0: if (drn) m_mode = 1;
      1: if (!drn) m_mode = 0; else if (old == CREDITS) m_mode = 2;
      default: if (!drn) m_mode = 0;
    endcase
    m_lv = acc;
    if (acc) m_ld = d;
  endtask

  initial begin
    logic        iv, ret, drn;
    logic [31:0] d;

    do_reset();
    chk("reset.link_valid", 64'(bus.link_valid), 64'd0);
    chk("reset.link_data",  64'(bus.link_data),  64'd0);
    chk("reset.credit_cnt", 64'(bus.credit_cnt), 64'd2);
    chk("reset.credit_err", 64'(bus.credit_err), 64'd0);
    chk("reset.drain_done", 64'(bus.drain_done), 64'd0);
    chk("reset.in_ready",   64'(bus.in_ready),   64'd1);
`ifdef FABRIC_CREDIT_TX_STATS_EN
    chk("reset.stat_beats",  64'(bus.stat_beats),  64'd0);
    chk("reset.stat_stalls", 64'(bus.stat_stalls), 64'd0);
`endif

    //  iv  data         ret  drn   rdy  lv  ld           cnt  err  dd
    add(1, 32'hA,        0,   0,    1,   1,  32'hA,       2'd1, 0,  0);
    add(1, 32'hB,        0,   0,    1,   1,  32'hB,       2'd0, 0,  0);
    add(1, 32'hC,        0,   0,    0,   0,  32'hB,       2'd0, 0,  0);
    add(1, 32'hC,        1,   0,    0,   0,  32'hB,       2'd1, 0,  0);
    add(1, 32'hC,        0,   0,    1,   1,  32'hC,       2'd0, 0,  0);
    add(0, 32'h0,        1,   0,    0,   0,  32'hC,       2'd1, 0,  0);
    for (int i = 0; i < 10; i++)
      add(1, 32'hD0 + i, 1,   0,    1,   1,  32'hD0 + i,  2'd1, 0,  0);
    add(0, 32'h0,        1,   0,    1,   0,  32'hD9,      2'd2, 0,  0);
    add(0, 32'h0,        1,   0,    1,   0,  32'hD9,      2'd2, 1,  0);
    add(0, 32'h0,        0,   0,    1,   0,  32'hD9,      2'd2, 1,  0);
    add(1, 32'hE0,       0,   0,    1,   1,  32'hE0,      2'd1, 1,  0);
    add(1, 32'hE1,       0,   0,    1,   1,  32'hE1,      2'd0, 1,  0);
    add(0, 32'h0,        0,   1,    0,   0,  32'hE1,      2'd0, 1,  0);
    add(1, 32'hFF,       1,   1,    0,   0,  32'hE1,      2'd1, 1,  0);
    add(1, 32'hFF,       0,   1,    0,   0,  32'hE1,      2'd1, 1,  0);
    add(1, 32'hFF,       0,   1,    0,   0,  32'hE1,      2'd1, 1,  0);
    add(1, 32'hFF,       1,   1,    0,   0,  32'hE1,      2'd2, 1,  0);
    add(1, 32'hFF,       0,   1,    0,   0,  32'hE1,      2'd2, 1,  1);
    add(0, 32'h0,        0,   0,    0,   0,  32'hE1,      2'd2, 1,  0);
    add(1, 32'hF,        0,   0,    1,   1,  32'hF,       2'd1, 1,  0);
    add(1, 32'h10,       0,   1,    1,   1,  32'h10,      2'd0, 1,  0);
    add(1, 32'h11,       0,   1,    0,   0,  32'h10,      2'd0, 1,  0);
    add(0, 32'h0,        0,   0,    0,   0,  32'h10,      2'd0, 1,  0);
    add(0, 32'h0,        1,   0,    0,   0,  32'h10,      2'd1, 1,  0);
    add(0, 32'h0,        1,   0,    1,   0,  32'h10,      2'd2, 1,  0);

    foreach (vecs[i]) begin
      drive(vecs[i].iv, vecs[i].d, vecs[i].ret, vecs[i].drn);
      #1;
      chk($sformatf("vec%0d.in_ready", i), 64'(bus.in_ready), 64'(vecs[i].rdy));
      @(negedge clk);
      chk($sformatf("vec%0d.link_valid", i), 64'(bus.link_valid), 64'(vecs[i].lv));
      chk($sformatf("vec%0d.link_data", i),  64'(bus.link_data),  64'(vecs[i].ld));
      chk($sformatf("vec%0d.credit_cnt", i), 64'(bus.credit_cnt), 64'(vecs[i].cnt));
      chk($sformatf("vec%0d.credit_err", i), 64'(bus.credit_err), 64'(vecs[i].err));
      chk($sformatf("vec%0d.drain_done", i), 64'(bus.drain_done), 64'(vecs[i].dd));
    end

    // Asynchronous reset while a link pulse is in flight
    drive(1'b1, 32'h55, 1'b0, 1'b0);
    @(negedge clk);
    chk("midreset.pulse_before", 64'(bus.link_valid), 64'd1);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset.link_valid", 64'(bus.link_valid), 64'd0);
    chk("midreset.credit_cnt", 64'(bus.credit_cnt), 64'd2);
    chk("midreset.link_data",  64'(bus.link_data),  64'd0);
    chk("midreset.credit_err", 64'(bus.credit_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef FABRIC_CREDIT_TX_STATS_EN
    do_reset();
    drive(1'b1, 32'h1, 1'b0, 1'b0); @(negedge clk);
    drive(1'b1, 32'h2, 1'b0, 1'b0); @(negedge clk);
    drive(1'b1, 32'h3, 1'b0, 1'b0); repeat (3) @(negedge clk);
    drive(1'b1, 32'h3, 1'b1, 1'b0); @(negedge clk);
    drive(1'b1, 32'h3, 1'b0, 1'b0); @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0); @(negedge clk);
    chk("stats.beats",  64'(bus.stat_beats),  64'd3);
    chk("stats.stalls", 64'(bus.stat_stalls), 64'd4);
`endif

    for (int blk = 0; blk < 6; blk++) begin
      do_reset();
      model_reset();
      drn = 1'b0;
      for (int c = 0; c < 500; c++) begin
        iv  = ($urandom_range(0, 9) < 7);
        d   = $urandom;
        ret = ($urandom_range(0, 9) < 4);
        if ($urandom_range(0, 24) == 0) drn = ~drn;
        drive(iv, d, ret, drn);
        #1;
        chk($sformatf("rnd%0d_%0d.in_ready", blk, c), 64'(bus.in_ready), 64'(model_ready()));
        model_step(iv, d, ret, drn);
        @(negedge clk);
        chk($sformatf("rnd%0d_%0d.link_valid", blk, c), 64'(bus.link_valid), 64'(m_lv));
        chk($sformatf("rnd%0d_%0d.link_data", blk, c),  64'(bus.link_data),  64'(m_ld));
        chk($sformatf("rnd%0d_%0d.credit_cnt", blk, c), 64'(bus.credit_cnt), 64'(m_cred));
        chk($sformatf("rnd%0d_%0d.credit_err", blk, c), 64'(bus.credit_err), 64'(m_err));
        chk($sformatf("rnd%0d_%0d.drain_done", blk, c), 64'(bus.drain_done), 64'(m_mode == 2));
`ifdef FABRIC_CREDIT_TX_STATS_EN
        chk($sformatf("rnd%0d_%0d.stat_beats", blk, c),  64'(bus.stat_beats),  64'(m_beats));
        chk($sformatf("rnd%0d_%0d.stat_stalls", blk, c), 64'(bus.stat_stalls), 64'(m_stalls));
`endif
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fabric_credit_tx.md
Name: fabric_credit_tx

Overview:
- Transmit end of a credit-based fabric link; the remote end is a fabric FIFO of depth CREDITS.
- Accepts a local valid/ready stream and forwards each accepted beat as a registered one-cycle link_valid pulse.
- Only forwards a beat while it holds a credit; the receiver returns one credit for each beat it drains.
- Includes a drain state machine so a producer can quiesce the link before reconfiguration.

Parameters:
CREDITS, 2, initial credit count = remote FIFO depth; must be >= 1 (elaboration $fatal otherwise)
DATA_WIDTH, 32, data bits per beat; must be > 0 (elaboration $fatal otherwise)
TAG_WIDTH, 0, tag bits appended above data; PAYLOAD_WIDTH = DATA_WIDTH + TAG_WIDTH
CNT_WIDTH (localparam), -, $clog2(CREDITS+1)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  local beat valid
in_ready  output  1  local beat accepted when in_valid && in_ready
in_data  input  PAYLOAD_WIDTH  local beat payload
link_valid  output  1  one-cycle pulse per forwarded beat; no backpressure on link side
link_data  output  PAYLOAD_WIDTH  forwarded payload, valid when link_valid=1
credit_ret  input  1  one credit returned per cycle when high
drain_req  input  1  level request to stop accepting and wait for all credits
drain_done  output  1  high while in DONE state
credit_cnt  output  CNT_WIDTH  current credits held
credit_err  output  1  sticky: credit returned while already holding CREDITS

Behaviour:
- Reset (async): credit_cnt=CREDITS, link_valid=0, link_data=0, credit_err=0, state=RUN, drain_done=0.
- in_ready = (state==RUN) && (credit_cnt != 0). Derived combinationally from registers only; no in_valid→in_ready path.
- Accept (in_valid && in_ready) on edge N:
  - link_valid=1 and link_data=in_data during cycle N+1; latency 1 cycle.
  - credit_cnt decrements.
- No accept: link_valid=0; link_data holds its last value.
- Credit update per cycle:
  - accept only: -1.
  - credit_ret only: +1.
  - accept and credit_ret together: unchanged.
  - credit_ret while credit_cnt==CREDITS with no accept: credit_cnt saturates at CREDITS and credit_err sets (sticky until reset).
- Back-to-back beats: allowed every cycle while credits remain. With credit_cnt==1 plus credit_ret in the same cycle, the count stays 1 and the next beat is still accepted.
- credit_cnt==0: in_ready=0. A credit_ret lifts in_ready on the following cycle.
- State machine:
  - RUN: normal operation. If drain_req=1 → DRAIN; in_ready drops the next cycle. A beat accepted in the same cycle drain_req rises is still sent.
  - DRAIN: in_ready=0; credit returns still counted. When credit_cnt==CREDITS → DONE.
  - DONE: drain_done=1, in_ready=0. When drain_req=0 → RUN.
- drain_req deasserted while in DRAIN → RUN immediately, even with credits outstanding.
- Reset mid-operation: any in-flight pulse is dropped and credits are restored to CREDITS. The system must reset the remote FIFO together with this block.

Optional Feature:
FABRIC_CREDIT_TX_STATS_EN
- Defined: adds outputs stat_beats [31:0] and stat_stalls [31:0], both reset to 0.
  - stat_beats increments on every accept.
  - stat_stalls increments on every cycle with in_valid=1, state==RUN and credit_cnt==0.
  - Both wrap at 2^32.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, CREDITS=2, credit_ret=0, in_valid=1 with data 0xA, 0xB, 0xC → link pulses 0xA and 0xB on consecutive cycles; in_ready=0 after the second accept; credit_cnt=0; 0xC held.
- From that stall, pulse credit_ret for 1 cycle → in_ready=1 the next cycle; 0xC sent; credit_cnt returns to 0.
- credit_cnt=1, accept and credit_ret in the same cycle, repeated 10 cycles → 10 consecutive link pulses; credit_cnt stays 1.
- Idle at credit_cnt=2, pulse credit_ret → credit_err=1 and stays 1; credit_cnt stays 2.
- Send 2 beats, raise drain_req, return 2 credits over 5 cycles → in_ready=0 throughout; drain_done=1 one cycle after the last credit; drop drain_req → RUN and in_ready=1.
- STATS_EN build, 3 beats accepted plus 4 zero-credit stall cycles → stat_beats=3, stat_stalls=4.
